recovery_sequencer: RTL and testbench
=====================================

Name: recovery_sequencer

Overview:
- Recovery FSM inside the pipeline controller. Arbitrates branch-mispredict and load/store-violation recovery requests by ROB age.
- Sequences the start/flush/rollback/stall outputs that feed the recovery fields of pipeline_control_recovery_io.
- Holds the pipeline until the ROB reports rollback complete, then replays any older pending request.

Parameters:
- ROB_TAG_W, 6, ROB tag width (ROB depth = 2**ROB_TAG_W).
- PERF_W, 32, width of the recovery event counter.

Ports:
- clk_i  in  1  core clock
- rst_i  in  1  reset; asynchronous, active-high
- rob_head_tag_i  in  ROB_TAG_W  tag of the oldest uncommitted ROB entry (age base)
- bp_PrMiss_i  in  1  branch mispredict resolved this cycle
- bp_miss_tag_i  in  ROB_TAG_W  ROB tag of the mispredicted branch
- load_store_violation_i  in  1  load buffer detected ordering violation
- load_store_violation_tag_i  in  ROB_TAG_W  ROB tag of the violating load
- ROB_recovery_finished_i  in  1  ROB rollback complete (level or pulse)
- recovery_start_o  out  1  one-cycle pulse, first cycle of a recovery
- recovery_flush_o  out  1  one-cycle pulse, squash cycle
- recovery_rollback_o  out  1  high while the ROB rolls back the rename map
- recovery_procedure_o  out  1  high from START through DONE
- recovery_stall_o  out  1  front-end/IQ stall, high from START through DONE
- flush_valid_o  out  1  broadcast valid (recovery_flush_BCAST.valid)
- flush_tag_o  out  ROB_TAG_W  broadcast boundary tag
- flush_incl_o  out  1  1: flush the boundary tag itself (load violation); 0: flush strictly younger (branch)
- recovery_count_o  out  PERF_W  number of recoveries started, wraps

Behaviour:
- Reset: state=IDLE, pending cleared, every output 0, counter 0. Reset asserted mid-recovery aborts immediately; no outputs are held.
- Age rule: age(t) = (t - rob_head_tag_i) mod 2**ROB_TAG_W. Smaller age is older. Equal tags: load violation wins because it is inclusive.
- Request selection in a cycle:
  - If both inputs fire, select the older one.
  - Branch gives boundary = bp_miss_tag_i, incl=0.
  - Load violation gives boundary = load_store_violation_tag_i, incl=1.
- FSM:
  - IDLE: on a selected request, latch {tag, incl} and go to START.
  - START (1 cycle): recovery_start_o=1. Counter increments by 1.
  - FLUSH (1 cycle): recovery_flush_o=1, flush_valid_o=1, flush_tag_o/flush_incl_o = latched values.
  - ROLLBACK: recovery_rollback_o=1. Stays until ROB_recovery_finished_i=1, then goes to DONE.
  - DONE (1 cycle): drains the stall. Goes to START if pending is valid (pending is loaded into current and cleared); otherwise goes to IDLE.
  - recovery_stall_o and recovery_procedure_o are 1 in START, FLUSH, ROLLBACK and DONE.
- Requests while not IDLE (compare against the current boundary):
  - Younger than current: dropped, since they are already squashed.
  - Older than current: stored in the single pending register. If pending is already valid, keep the older of the two.
  - Same tag, branch vs load: treat the load as older.
- Latency: request at cycle N gives start at N+1, flush at N+2, rollback from N+3.
- ROB_recovery_finished_i asserted in START or FLUSH: ignored; it is sampled only in ROLLBACK.
- Outputs are registered from state; no combinational input-to-output path.

Decomposition:
- Falco_pkg additions:
  - rec_state_t enum {IDLE, START, FLUSH, ROLLBACK, DONE}
  - rec_req_t struct {tag, incl}
  - function rob_age(tag, head)
  - existing rob_tag_t / branch_flush_t reused for the flush_* fields.
- One sub-module: rob_age_arbiter. It is combinational: picks the older of two rec_req_t and is used twice (input select and pending compare).

Test Plan:
1. Reset, then bp_PrMiss_i with tag=5, head=0 -> start at +1; flush at +2 with tag=5, incl=0; rollback held until finished is driven at +7; DONE at +8; IDLE at +9; count=1.
2. Same cycle: branch tag=10 and load violation tag=4, head=2 -> latched tag=4, incl=1.
3. Wrap-around: head=60, branch tag=62 and load violation tag=1 in the same cycle -> 62 selected (age 2 < age 5).
4. During ROLLBACK for tag=20 (head=0): violation tag=25 -> dropped. Branch tag=8 -> pending. After DONE a second START with flush tag=8, incl=0; count=2.
5. Two older requests during ROLLBACK for tag=30: tag=12, then tag=9 -> pending holds 9; tag=12 is discarded.
6. rst_i asserted asynchronously in ROLLBACK -> all outputs 0 within the same cycle; with no new request, state stays IDLE.

Source files
------------

// File: rtl/recovery_sequencer_pkg.sv
// Shared types and ROB-age helpers for the recovery sequencer.
package recovery_sequencer_pkg;

  localparam int unsigned REC_TAG_W  = 6;
  localparam int unsigned REC_PERF_W = 32;

  typedef logic [REC_TAG_W-1:0] rob_tag_t;

  typedef enum logic [2:0] {
    IDLE,
    START,
    FLUSH,
    ROLLBACK,
    DONE
  } rec_state_t;

  // Recovery boundary: incl=1 squashes the boundary tag itself
  typedef struct packed {
    rob_tag_t tag;
    logic     incl;
  } rec_req_t;

  typedef struct packed {
    logic     valid;
    rob_tag_t tag;
    logic     incl;
  } branch_flush_t;

  // Distance from the ROB head; smaller means older
  function automatic rob_tag_t rob_age(input rob_tag_t tag, input rob_tag_t head);
    return tag - head;
  endfunction

  // True when a is strictly older than b; an inclusive boundary wins a tag tie
  function automatic logic req_older(input rec_req_t a, input rec_req_t b, input rob_tag_t head);
    rob_tag_t age_a;
    rob_tag_t age_b;
    age_a = rob_age(a.tag, head);
    age_b = rob_age(b.tag, head);
    return (age_a < age_b) || ((age_a == age_b) && a.incl && !b.incl);
  endfunction

endpackage

// File: rtl/recovery_sequencer_arbiter.sv
// Combinational pick of the older of two optional recovery requests.
module rob_age_arbiter
  import recovery_sequencer_pkg::*;
(
  input  rob_tag_t head,
  input  logic     a_valid,
  input  rec_req_t a,
  input  logic     b_valid,
  input  rec_req_t b,
  output logic     y_valid_c,
  output rec_req_t y_c
);

  logic pick_a;

  // a wins only if strictly older than a valid b; ties keep b
  always_comb begin
    pick_a    = a_valid && (!b_valid || req_older(a, b, head));
    y_valid_c = a_valid || b_valid;
    y_c       = pick_a ? a : b;
  end

endmodule

// File: rtl/recovery_sequencer.sv
// Recovery FSM: arbitrates mispredict / ordering-violation recoveries by ROB age.
module recovery_sequencer
  import recovery_sequencer_pkg::*;
#(
  parameter int unsigned ROB_TAG_W = REC_TAG_W,
  parameter int unsigned PERF_W    = REC_PERF_W
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic [ROB_TAG_W-1:0] rob_head_tag_i,
  input  logic                 bp_PrMiss_i,
  input  logic [ROB_TAG_W-1:0] bp_miss_tag_i,
  input  logic                 load_store_violation_i,
  input  logic [ROB_TAG_W-1:0] load_store_violation_tag_i,
  input  logic                 ROB_recovery_finished_i,
  output logic                 recovery_start_o,
  output logic                 recovery_flush_o,
  output logic                 recovery_rollback_o,
  output logic                 recovery_procedure_o,
  output logic                 recovery_stall_o,
  output logic                 flush_valid_o,
  output logic [ROB_TAG_W-1:0] flush_tag_o,
  output logic                 flush_incl_o,
  output logic [PERF_W-1:0]    recovery_count_o
);

  rec_state_t    state;
  rec_req_t      cur;
  rec_req_t      pend;
  logic          pend_valid;
  branch_flush_t flush_q;

  rec_req_t br_req;
  rec_req_t ld_req;
  rec_req_t sel_req;
  logic     sel_valid;
  logic     cand_keep;
  rec_req_t merged_req;
  logic     merged_valid;

  // Requests presented as boundaries: branch keeps itself, load squashes itself
  always_comb begin
    br_req    = '{tag: bp_miss_tag_i, incl: 1'b0};
    ld_req    = '{tag: load_store_violation_tag_i, incl: 1'b1};
    cand_keep = sel_valid && req_older(sel_req, cur, rob_head_tag_i);
  end

  rob_age_arbiter u_sel_arb (
    .head      (rob_head_tag_i),
    .a_valid   (load_store_violation_i),
    .a         (ld_req),
    .b_valid   (bp_PrMiss_i),
    .b         (br_req),
    .y_valid_c (sel_valid),
    .y_c       (sel_req)
  );

  // Only requests older than the active boundary compete with the pending slot
  rob_age_arbiter u_pend_arb (
    .head      (rob_head_tag_i),
    .a_valid   (cand_keep),
    .a         (sel_req),
    .b_valid   (pend_valid),
    .b         (pend),
    .y_valid_c (merged_valid),
    .y_c       (merged_req)
  );

  // Sequencer state, pending slot and registered outputs
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state                <= IDLE;
      cur                  <= '0;
      pend                 <= '0;
      pend_valid           <= 1'b0;
      flush_q              <= '0;
      recovery_start_o     <= 1'b0;
      recovery_flush_o     <= 1'b0;
      recovery_rollback_o  <= 1'b0;
      recovery_procedure_o <= 1'b0;
      recovery_stall_o     <= 1'b0;
      recovery_count_o     <= '0;
    end else begin
      recovery_start_o     <= 1'b0;
      recovery_flush_o     <= 1'b0;
      recovery_rollback_o  <= 1'b0;
      recovery_procedure_o <= 1'b1;
      recovery_stall_o     <= 1'b1;
      flush_q              <= '0;

      if ((state == START || state == FLUSH || state == ROLLBACK) && merged_valid) begin
        pend       <= merged_req;
        pend_valid <= 1'b1;
      end

      case (state)
        IDLE: begin
          if (sel_valid) begin
            state            <= START;
            cur              <= sel_req;
            recovery_start_o <= 1'b1;
          end else begin
            recovery_procedure_o <= 1'b0;
            recovery_stall_o     <= 1'b0;
          end
        end
        START: begin
          state            <= FLUSH;
          recovery_count_o <= recovery_count_o + PERF_W'(1);
          recovery_flush_o <= 1'b1;
          flush_q          <= '{valid: 1'b1, tag: cur.tag, incl: cur.incl};
        end
        FLUSH: begin
          state               <= ROLLBACK;
          recovery_rollback_o <= 1'b1;
        end
        ROLLBACK: begin
          if (ROB_recovery_finished_i) begin
            state <= DONE;
          end else begin
            recovery_rollback_o <= 1'b1;
          end
        end
        DONE: begin
          pend_valid <= 1'b0;
          if (merged_valid) begin
            state            <= START;
            cur              <= merged_req;
            recovery_start_o <= 1'b1;
          end else begin
            state                <= IDLE;
            recovery_procedure_o <= 1'b0;
            recovery_stall_o     <= 1'b0;
          end
        end
        default: begin
          state                <= IDLE;
          recovery_procedure_o <= 1'b0;
          recovery_stall_o     <= 1'b0;
        end
      endcase
    end
  end

  assign flush_valid_o = flush_q.valid;
  assign flush_tag_o   = flush_q.tag;
  assign flush_incl_o  = flush_q.incl;

endmodule

// File: tb/tb_recovery_sequencer.sv
// Self-checking bench for recovery_sequencer against a phase-level reference model.
module tb_recovery_sequencer;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic [5:0]  rob_head_tag_i;
  logic        bp_PrMiss_i;
  logic [5:0]  bp_miss_tag_i;
  logic        load_store_violation_i;
  logic [5:0]  load_store_violation_tag_i;
  logic        ROB_recovery_finished_i;
  logic        recovery_start_o;
  logic        recovery_flush_o;
  logic        recovery_rollback_o;
  logic        recovery_procedure_o;
  logic        recovery_stall_o;
  logic        flush_valid_o;
  logic [5:0]  flush_tag_o;
  logic        flush_incl_o;
  logic [31:0] recovery_count_o;

  int total = 0;
  int bad   = 0;

  // Reference model: phase 0 idle, 1 start, 2 flush, 3 rollback, 4 done
  int          m_ph;
  int          m_ct;
  bit          m_ci;
  bit          m_pv;
  int          m_pt;
  bit          m_pi;
  logic [31:0] m_cnt;

  recovery_sequencer dut (
    .clk_i                      (clk_i),
    .rst_i                      (rst_i),
    .rob_head_tag_i             (rob_head_tag_i),
    .bp_PrMiss_i                (bp_PrMiss_i),
    .bp_miss_tag_i              (bp_miss_tag_i),
    .load_store_violation_i     (load_store_violation_i),
    .load_store_violation_tag_i (load_store_violation_tag_i),
    .ROB_recovery_finished_i    (ROB_recovery_finished_i),
    .recovery_start_o           (recovery_start_o),
    .recovery_flush_o           (recovery_flush_o),
    .recovery_rollback_o        (recovery_rollback_o),
    .recovery_procedure_o       (recovery_procedure_o),
    .recovery_stall_o           (recovery_stall_o),
    .flush_valid_o              (flush_valid_o),
    .flush_tag_o                (flush_tag_o),
    .flush_incl_o               (flush_incl_o),
    .recovery_count_o           (recovery_count_o)
  );

  always #5 clk_i = ~clk_i;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic int age(int t);
    return (t - int'(rob_head_tag_i) + 64) % 64;
  endfunction

  function automatic bit older(int at, bit ai, int bt, bit bi);
    return (age(at) < age(bt)) || ((age(at) == age(bt)) && ai && !bi);
  endfunction

  function automatic logic [12:0] obs_vec();
    return {recovery_start_o, recovery_flush_o, recovery_rollback_o, recovery_procedure_o,
            recovery_stall_o, flush_valid_o, flush_incl_o, flush_tag_o};
  endfunction

  function automatic logic [12:0] exp_vec();
    logic [12:0] e;
    e = '0;
    e[12] = (m_ph == 1);
    e[11] = (m_ph == 2);
    e[10] = (m_ph == 3);
    e[9]  = (m_ph != 0);
    e[8]  = (m_ph != 0);
    e[7]  = (m_ph == 2);
    e[6]  = (m_ph == 2) ? m_ci : 1'b0;
    e[5:0] = (m_ph == 2) ? 6'(m_ct) : 6'd0;
    return e;
  endfunction

  task automatic m_reset();
    m_ph = 0; m_ct = 0; m_ci = 0; m_pv = 0; m_pt = 0; m_pi = 0; m_cnt = '0;
  endtask

  // Advance the model by one clock using the inputs currently applied
  task automatic model_advance();
    bit cv;
    int ct;
    bit ci;
    bit cand_older;
    cv = bp_PrMiss_i || load_store_violation_i;
    if (load_store_violation_i &&
        (!bp_PrMiss_i || age(int'(load_store_violation_tag_i)) <= age(int'(bp_miss_tag_i)))) begin
      ct = int'(load_store_violation_tag_i); ci = 1'b1;
    end else begin
      ct = int'(bp_miss_tag_i); ci = 1'b0;
    end
    cand_older = cv && older(ct, ci, m_ct, m_ci) && (!m_pv || older(ct, ci, m_pt, m_pi));
    case (m_ph)
      0: if (cv) begin m_ct = ct; m_ci = ci; m_ph = 1; end
      1, 2, 3: begin
        if (cand_older) begin m_pv = 1; m_pt = ct; m_pi = ci; end
        if (m_ph == 1) begin m_cnt = m_cnt + 1; m_ph = 2; end
        else if (m_ph == 2) m_ph = 3;
        else if (ROB_recovery_finished_i) m_ph = 4;
      end
      default: begin
        if (cand_older) begin m_ct = ct; m_ci = ci; m_ph = 1; end
        else if (m_pv) begin m_ct = m_pt; m_ci = m_pi; m_ph = 1; end
        else m_ph = 0;
        m_pv = 0;
      end
    endcase
  endtask

  task automatic tick();
    @(negedge clk_i);
    model_advance();
    @(posedge clk_i);
    #1;
  endtask

  task automatic drive(bit bp, int bt, bit lv, int lt, bit fin);
    bp_PrMiss_i                = bp;
    bp_miss_tag_i              = 6'(bt);
    load_store_violation_i     = lv;
    load_store_violation_tag_i = 6'(lt);
    ROB_recovery_finished_i    = fin;
  endtask

  task automatic do_reset();
    rst_i = 1'b1;
    drive(0, 0, 0, 0, 0);
    @(posedge clk_i); #1;
    @(posedge clk_i); #1;
    rst_i = 1'b0;
    m_reset();
  endtask

  task automatic test_reset();
    rst_i = 1'b1;
    rob_head_tag_i = '0;
    drive(0, 0, 0, 0, 0);
    @(posedge clk_i); #1;
    total++;
    if (obs_vec() !== 13'd0 || recovery_count_o !== 32'd0) begin
      bad++;
      $display("FAIL reset_outputs got %h/%0d want 0/0", obs_vec(), recovery_count_o);
    end
    rst_i = 1'b0;
    m_reset();
  endtask

  task automatic test_single_branch();
    do_reset();
    rob_head_tag_i = 6'd0;
    for (int k = 0; k < 11; k++) begin
      drive(k == 0, 5, 0, 0, (k == 1) || (k == 2) || (k == 7));
      tick();
      total++;
      if (obs_vec() !== exp_vec() || recovery_count_o !== m_cnt) begin
        bad++;
        $display("FAIL single_branch cyc%0d got %h cnt %0d want %h cnt %0d",
                 k + 1, obs_vec(), recovery_count_o, exp_vec(), m_cnt);
      end
      if (k + 1 == 2) begin
        total++;
        if (flush_tag_o !== 6'd5 || flush_incl_o !== 1'b0 || flush_valid_o !== 1'b1) begin
          bad++;
          $display("FAIL single_branch_flush got tag %0d incl %0b v %0b want 5 0 1",
                   flush_tag_o, flush_incl_o, flush_valid_o);
        end
      end
      if (k + 1 == 7) begin
        total++;
        if (recovery_rollback_o !== 1'b1) begin
          bad++;
          $display("FAIL single_branch_rb_hold got %0b want 1", recovery_rollback_o);
        end
      end
      if (k + 1 == 9) begin
        total++;
        if (recovery_procedure_o !== 1'b0 || recovery_count_o !== 32'd1) begin
          bad++;
          $display("FAIL single_branch_idle got proc %0b cnt %0d want 0 1",
                   recovery_procedure_o, recovery_count_o);
        end
      end
    end
  endtask

  task automatic test_same_cycle(int head, int bt, int lt, int want_tag, bit want_incl, string nm);
    do_reset();
    rob_head_tag_i = 6'(head);
    for (int k = 0; k < 6; k++) begin
      drive(k == 0, bt, k == 0, lt, k == 4);
      tick();
      total++;
      if (obs_vec() !== exp_vec() || recovery_count_o !== m_cnt) begin
        bad++;
        $display("FAIL %s cyc%0d got %h want %h", nm, k + 1, obs_vec(), exp_vec());
      end
      if (k + 1 == 2) begin
        total++;
        if (flush_tag_o !== 6'(want_tag) || flush_incl_o !== want_incl) begin
          bad++;
          $display("FAIL %s_select got tag %0d incl %0b want %0d %0b",
                   nm, flush_tag_o, flush_incl_o, want_tag, want_incl);
        end
      end
    end
  endtask

  task automatic test_drop_and_pending();
    do_reset();
    rob_head_tag_i = 6'd0;
    for (int k = 0; k < 18; k++) begin
      drive((k == 0) || (k == 5), (k == 0) ? 20 : 8, k == 4, 25, (k == 8) || (k == 14));
      tick();
      total++;
      if (obs_vec() !== exp_vec() || recovery_count_o !== m_cnt) begin
        bad++;
        $display("FAIL drop_pending cyc%0d got %h cnt %0d want %h cnt %0d",
                 k + 1, obs_vec(), recovery_count_o, exp_vec(), m_cnt);
      end
      if (k + 1 == 11) begin
        total++;
        if (flush_tag_o !== 6'd8 || flush_incl_o !== 1'b0 || recovery_count_o !== 32'd2) begin
          bad++;
          $display("FAIL drop_pending_replay got tag %0d incl %0b cnt %0d want 8 0 2",
                   flush_tag_o, flush_incl_o, recovery_count_o);
        end
      end
    end
  endtask

  task automatic test_back_to_back_pending();
    do_reset();
    rob_head_tag_i = 6'd0;
    for (int k = 0; k < 17; k++) begin
      drive((k == 0) || (k == 4), (k == 0) ? 30 : 12, k == 5, 9, (k == 7) || (k == 13));
      tick();
      total++;
      if (obs_vec() !== exp_vec() || recovery_count_o !== m_cnt) begin
        bad++;
        $display("FAIL keep_older cyc%0d got %h want %h", k + 1, obs_vec(), exp_vec());
      end
      if (k + 1 == 10) begin
        total++;
        if (flush_tag_o !== 6'd9 || flush_incl_o !== 1'b1) begin
          bad++;
          $display("FAIL keep_older_replay got tag %0d incl %0b want 9 1", flush_tag_o, flush_incl_o);
        end
      end
    end
    total++;
    if (recovery_procedure_o !== 1'b0 || recovery_count_o !== 32'd2) begin
      bad++;
      $display("FAIL keep_older_final got proc %0b cnt %0d want 0 2",
               recovery_procedure_o, recovery_count_o);
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    rob_head_tag_i = 6'd0;
    for (int k = 0; k < 4; k++) begin
      drive(k == 0, 17, 0, 0, 0);
      tick();
    end
    total++;
    if (recovery_rollback_o !== 1'b1) begin
      bad++;
      $display("FAIL async_reset_pre got rollback %0b want 1", recovery_rollback_o);
    end
    #2 rst_i = 1'b1;
    #1;
    total++;
    if (obs_vec() !== 13'd0 || recovery_count_o !== 32'd0) begin
      bad++;
      $display("FAIL async_reset_now got %h cnt %0d want 0 0", obs_vec(), recovery_count_o);
    end
    @(negedge clk_i);
    rst_i = 1'b0;
    m_reset();
    @(posedge clk_i); #1;
    for (int k = 0; k < 4; k++) begin
      drive(0, 0, 0, 0, k[0]);
      tick();
      total++;
      if (obs_vec() !== 13'd0 || recovery_count_o !== 32'd0) begin
        bad++;
        $display("FAIL async_reset_idle cyc%0d got %h want 0", k, obs_vec());
      end
    end
  endtask

  task automatic test_random();
    do_reset();
    rob_head_tag_i = 6'($urandom_range(0, 63));
    for (int k = 0; k < 1500; k++) begin
      if ($urandom_range(0, 15) == 0) rob_head_tag_i = 6'($urandom_range(0, 63));
      drive($urandom_range(0, 7) == 0, $urandom_range(0, 63),
            $urandom_range(0, 7) == 0, $urandom_range(0, 63),
            $urandom_range(0, 3) == 0);
      tick();
      total++;
      if (obs_vec() !== exp_vec() || recovery_count_o !== m_cnt) begin
        bad++;
        $display("FAIL random cyc%0d got %h cnt %0d want %h cnt %0d",
                 k, obs_vec(), recovery_count_o, exp_vec(), m_cnt);
      end
    end
  endtask

  initial begin
    test_reset();
    test_single_branch();
    test_same_cycle(2, 10, 4, 4, 1'b1, "same_cycle");
    test_same_cycle(60, 62, 1, 62, 1'b0, "wrap_select");
    test_same_cycle(7, 20, 20, 20, 1'b1, "equal_tag");
    test_drop_and_pending();
    test_back_to_back_pending();
    test_async_reset();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
